// File: rtl/fetch_queue.sv
// Instruction buffer between the ifu and decode: a small circular FIFO of
// {instruction, PC} pairs with show-ahead head, valid/ready handshake and flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_instr,
  input  logic [DW-1:0] in_pc,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_instr,
  output logic [DW-1:0] out_pc,
  input  logic          out_ready,
  input  logic          flush,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [2*DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign count     = r_count;

  // Empty queue presents a NOP at PC 0 so decode never sees stale storage.
  assign out_instr = out_valid ? r_mem[r_rdPtr][2*DW-1:DW] : '0;
  assign out_pc    = out_valid ? r_mem[r_rdPtr][DW-1:0]    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset; it is only observed while the entry is occupied.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wrPtr] <= {in_instr, in_pc};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: reset, fill/drain, wrap,
// flush, asynchronous reset and full-with-pop scenarios.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int vectors;
  int miscompares;

  fetch_queue #(.DEPTH(4), .AW(2), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; checks and drives happen there.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (count !== 3'd0) begin
      miscompares++; $display("[TB] FAIL reset_count got %0d expected 0", count);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready);
    end
    vectors++;
    if (out_instr !== 32'h0 || out_pc !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_head got %h/%h expected 00000000/00000000", out_instr, out_pc);
    end
  endtask

  task automatic test_fill_drain;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h20080001 + i;
      in_pc    = 32'h00400000 + 4 * i;
      tick();
      vectors++;
      if (count !== 3'(i + 1)) begin
        miscompares++; $display("[TB] FAIL fill_count[%0d] got %0d expected %0d", i, count, i + 1);
      end
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL full_in_ready got %b expected 0", in_ready);
    end
    in_instr = 32'h20080005;
    in_pc    = 32'h00400010;
    tick();
    vectors++;
    if (count !== 3'd4 || out_instr !== 32'h20080001 || out_pc !== 32'h00400000) begin
      miscompares++;
      $display("[TB] FAIL refused_push got count %0d head %h/%h expected 4 20080001/00400000",
               count, out_instr, out_pc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_instr !== 32'h20080001 + i || out_pc !== 32'h00400000 + 4 * i) begin
        miscompares++;
        $display("[TB] FAIL drain[%0d] got v=%b %h/%h expected v=1 %h/%h", i, out_valid,
                 out_instr, out_pc, 32'h20080001 + i, 32'h00400000 + 4 * i);
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL drained got count %0d v=%b instr %h expected 0 0 00000000",
               count, out_valid, out_instr);
    end
  endtask

  task automatic test_wrap;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_instr = 32'h24000000 + k;
      in_pc    = 32'h00400000 + 4 * k;
      if (k > 0) begin
        vectors++;
        if (count !== 3'd1 || out_pc !== 32'h00400000 + 4 * (k - 1) ||
            out_instr !== 32'h24000000 + (k - 1)) begin
          miscompares++;
          $display("[TB] FAIL wrap[%0d] got count %0d head %h/%h expected 1 %h/%h", k, count,
                   out_instr, out_pc, 32'h24000000 + (k - 1), 32'h00400000 + 4 * (k - 1));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd1 || out_pc !== 32'h0040002C) begin
      miscompares++;
      $display("[TB] FAIL wrap_last got count %0d pc %h expected 1 0040002c", count, out_pc);
    end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (count !== 3'd0) begin
      miscompares++; $display("[TB] FAIL wrap_empty got %0d expected 0", count);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h8C000000 + i;
      in_pc    = 32'h00400020 + 4 * i;
      tick();
    end
    vectors++;
    if (count !== 3'd3) begin
      miscompares++; $display("[TB] FAIL flush_pre_count got %0d expected 3", count);
    end
    flush     = 1'b1;
    in_instr  = 32'hDEADBEEF;
    in_pc     = 32'h00400040;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL flush_state got count %0d v=%b rdy=%b pc %h expected 0 0 1 00000000",
               count, out_valid, in_ready, out_pc);
    end
    in_valid = 1'b1;
    in_instr = 32'h20090100;
    in_pc    = 32'h00400100;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 32'h00400100 ||
        out_instr !== 32'h20090100) begin
      miscompares++;
      $display("[TB] FAIL post_flush_head got count %0d v=%b %h/%h expected 1 1 20090100/00400100",
               count, out_valid, out_instr, out_pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_empty got count %0d v=%b rdy=%b expected 0 0 1",
               count, out_valid, in_ready);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h3C010000 + i;
      in_pc    = 32'h00400180 + 4 * i;
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd2) begin
      miscompares++; $display("[TB] FAIL areset_pre_count got %0d expected 2", count);
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL areset_immediate got count %0d v=%b pc %h expected 0 0 00000000",
               count, out_valid, out_pc);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h20100200;
    in_pc    = 32'h00400200;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd1 || out_pc !== 32'h00400200 || out_instr !== 32'h20100200) begin
      miscompares++;
      $display("[TB] FAIL areset_push got count %0d head %h/%h expected 1 20100200/00400200",
               count, out_instr, out_pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = 32'hAC000300 + i;
      in_pc    = 32'h00400300 + 4 * i;
      tick();
    end
    vectors++;
    if (count !== 3'd4) begin
      miscompares++; $display("[TB] FAIL fullpop_pre_count got %0d expected 4", count);
    end
    in_instr  = 32'hAC000304;
    in_pc     = 32'h00400310;
    out_ready = 1'b1;
    tick();
    vectors++;
    if (count !== 3'd3 || out_pc !== 32'h00400304) begin
      miscompares++;
      $display("[TB] FAIL fullpop_pop_only got count %0d pc %h expected 3 00400304", count, out_pc);
    end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd4) begin
      miscompares++; $display("[TB] FAIL fullpop_accept got %0d expected 4", count);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      vectors++;
      if (out_pc !== 32'h00400300 + 4 * i || out_instr !== 32'hAC000300 + i) begin
        miscompares++;
        $display("[TB] FAIL fullpop_order[%0d] got %h/%h expected %h/%h", i, out_instr, out_pc,
                 32'hAC000300 + i, 32'h00400300 + 4 * i);
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (count !== 3'd0) begin
      miscompares++; $display("[TB] FAIL fullpop_empty got %0d expected 0", count);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_async_reset();
    test_full_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
